// File: rtl/execute_muldiv.sv
// ---------------------------------------------------------------------------
// execute_muldiv -- iterative RV64M multiply/divide unit
//
// Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms one bit per
// cycle on operand magnitudes. The sign is fixed up on the way into DONE.
// Multiply is radix-2 shift-add into a 2*XLEN product. Divide is restoring
// division. W forms run 32 iterations instead of XLEN.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, these cases go from IDLE straight to DONE:
//     - divide by zero
//     - signed overflow (most-negative / -1)
//     - multiply with a zero operand magnitude
//   Results are the same with or without the macro.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid_i        request valid
//   in_ready_o        unit idle, can accept
//   md_op_i[7:0]      one-hot op: mul mulh mulhsu mulhu div divu rem remu
//   word_i            W-form; ignored for mulh/mulhsu/mulhu
//   rs1_data_i        operand 1
//   rs2_data_i        operand 2
//   tag_i             destination tag
//   flush_i           abort whatever is in flight
//   out_valid_o       result valid
//   out_ready_i       consumer takes result
//   result_o          result
//   tag_o             tag of result
// ---------------------------------------------------------------------------
module execute_muldiv #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       md_op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  // A W-form dividend is parked in the top 32 bits so that 32 iterations
  // consume exactly its bits. The W-form product likewise lands SH bits up.
  localparam int SH    = XLEN - 32;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  // Per-operation control latched at accept.
  typedef struct packed {
    logic is_mul;    // any multiply
    logic hi_sel;    // mulh/mulhsu/mulhu: take the upper product half
    logic is_rem;    // rem/remu
    logic word;      // effective W-form
    logic neg_p;     // negate product / quotient
    logic neg_r;     // negate remainder
    logic div_zero;  // divisor magnitude is zero
  } ctl_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  state_e            state, state_nxt;
  ctl_t              ctl, req_ctl;
  logic              accept;
  logic              mulh_in, is_mul_in, s1_sgn, s2_sgn, word_eff, neg1, neg2;
  logic [XLEN-1:0]   op1, op2, mag1, mag2;

  logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [XLEN-1:0]   quo;        // dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   rem_r;      // partial remainder
  logic [2*XLEN-1:0] prod;       // {partial product, remaining multiplier}
  logic [CNT_W-1:0]  cnt;

  logic              early_take;
  logic [XLEN-1:0]   early_res;

  logic [XLEN:0]     msum, dshift, ddiff;
  logic [2*XLEN-1:0] prod_nxt, prod_fin;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fin, rem_fin, sel_raw, fin_res;

  // -------------------------------------------------------------------------
  // Operand preparation: extend per signedness, then take magnitudes.
  // -------------------------------------------------------------------------
  always_comb begin
    mulh_in   = |md_op_i[3:1];
    is_mul_in = |md_op_i[3:0];
    word_eff  = word_i & ~mulh_in;
    s1_sgn    = md_op_i[0] | md_op_i[1] | md_op_i[2] | md_op_i[4] | md_op_i[6];
    s2_sgn    = md_op_i[0] | md_op_i[1] | md_op_i[4] | md_op_i[6];
    op1       = rs1_data_i;
    op2       = rs2_data_i;
    if (word_eff) begin
      op1 = s1_sgn ? sext32(rs1_data_i[31:0]) : XLEN'(rs1_data_i[31:0]);
      op2 = s2_sgn ? sext32(rs2_data_i[31:0]) : XLEN'(rs2_data_i[31:0]);
    end
    neg1 = s1_sgn & op1[XLEN-1];
    neg2 = s2_sgn & op2[XLEN-1];
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;

    req_ctl          = '0;
    req_ctl.is_mul   = is_mul_in;
    req_ctl.hi_sel   = mulh_in;
    req_ctl.is_rem   = md_op_i[6] | md_op_i[7];
    req_ctl.word     = word_eff;
    req_ctl.neg_p    = neg1 ^ neg2;
    req_ctl.neg_r    = neg1;
    req_ctl.div_zero = (mag2 == '0);
  end

  assign accept = in_valid_i & (state == IDLE) & ~flush_i;

  // -------------------------------------------------------------------------
  // Early-out detection (optional)
  // -------------------------------------------------------------------------
`ifdef MULDIV_EARLY_OUT_EN
  logic is_div_in, min_op1, neg1_op2, ovf_in;

  always_comb begin
    is_div_in  = |md_op_i[7:4];
    min_op1    = word_eff ? (op1[31:0] == 32'h8000_0000)
                          : (op1 == {1'b1, {(XLEN-1){1'b0}}});
    neg1_op2   = word_eff ? (&op2[31:0]) : (&op2);
    ovf_in     = s2_sgn & is_div_in & min_op1 & neg1_op2;
    early_take = 1'b0;
    early_res  = '0;
    if (is_mul_in & ((mag1 == '0) | (mag2 == '0))) begin
      early_take = 1'b1;
    end else if (is_div_in & (mag2 == '0)) begin
      early_take = 1'b1;
      early_res  = req_ctl.is_rem ? (word_eff ? sext32(op1[31:0]) : op1) : '1;
    end else if (ovf_in) begin
      early_take = 1'b1;
      early_res  = req_ctl.is_rem ? '0
                 : (word_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}});
    end
  end
`else
  assign early_take = 1'b0;
  assign early_res  = '0;
`endif

  // -------------------------------------------------------------------------
  // One iteration of each algorithm
  // -------------------------------------------------------------------------
  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set. Then shift the whole product right, carry
    // included.
    msum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    prod_nxt = {msum, prod[XLEN-1:1]};

    // Restoring divide: the remainder stays below the divisor. The trial
    // difference therefore fits XLEN+1 bits, and its top bit is the borrow.
    // A zero divisor never borrows. That yields an all-ones quotient and the
    // dividend as remainder.
    dshift = {rem_r, quo[XLEN-1]};
    ddiff  = dshift - {1'b0, opnd};
    if (ddiff[XLEN]) begin
      rem_nxt = dshift[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = ddiff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end

  // -------------------------------------------------------------------------
  // Sign correction and result selection, applied on the last iteration
  // -------------------------------------------------------------------------
  always_comb begin
    prod_fin = ctl.neg_p ? -prod_nxt : prod_nxt;
    // A zero divisor always gives -1, whatever the dividend sign.
    quo_fin  = ctl.div_zero ? '1 : (ctl.neg_p ? -quo_nxt : quo_nxt);
    rem_fin  = ctl.neg_r ? -rem_nxt : rem_nxt;
    if (ctl.is_mul) begin
      if (ctl.word)        sel_raw = prod_fin[SH +: XLEN];
      else if (ctl.hi_sel) sel_raw = prod_fin[2*XLEN-1:XLEN];
      else                 sel_raw = prod_fin[XLEN-1:0];
    end else if (ctl.is_rem) begin
      sel_raw = rem_fin;
    end else begin
      sel_raw = quo_fin;
    end
    fin_res = ctl.word ? sext32(sel_raw[31:0]) : sel_raw;
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early_take ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_comb begin
    in_ready_o  = (state == IDLE);
    out_valid_o = (state == DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl      <= '0;
      opnd     <= '0;
      quo      <= '0;
      rem_r    <= '0;
      prod     <= '0;
      cnt      <= '0;
      result_o <= '0;
      tag_o    <= '0;
    end else if (accept) begin
      ctl   <= req_ctl;
      tag_o <= tag_i;
      opnd  <= is_mul_in ? mag1 : mag2;
      prod  <= {{XLEN{1'b0}}, mag2};
      quo   <= word_eff ? (mag1 << SH) : mag1;
      rem_r <= '0;
      cnt   <= word_eff ? CNT_W'(32) : CNT_W'(XLEN);
      if (early_take) result_o <= early_res;
    end else if (state == CALC && !flush_i) begin
      cnt <= cnt - CNT_W'(1);
      if (ctl.is_mul) begin
        prod <= prod_nxt;
      end else begin
        quo   <= quo_nxt;
        rem_r <= rem_nxt;
      end
      if (cnt == CNT_W'(1)) result_o <= fin_res;
    end
  end

endmodule
